// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Constants shared by the UART transmitter and receiver, receiver state encoding,
// and the baud divisor helper.
package uart_pkg;

  localparam int UART_CLK_FREQ  = 50_000_000;
  localparam int UART_BAUD      = 115_200;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  // Clock cycles per oversample tick, truncated.
  function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// Receiver-to-consumer bundle: received byte under valid/ack plus line status flags.
// The master side is the receiver; the slave side consumes bytes and drives rx_ack.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ack;
  logic                      rx_busy;
  logic                      frame_err;
  logic                      parity_err;
  logic                      overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_ack
  );

endinterface

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: tick pulses for one cycle every DIV clocks, one cycle after the
// sample count advances; mid flags the half-bit sample count. restart zeroes both counters.
module uart_baud_tick #(
  parameter int DIV        = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic mid
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2);

  logic [CW-1:0] cnt;
  logic [SW-1:0] smp;

  // tick is registered so that, while it is high, smp already shows the new count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      smp  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      smp  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        smp <= (smp == SMP_LAST) ? '0 : smp + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign mid = (smp == SMP_MID);

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined); byte valid 152*DIV+3 edges
// (168*DIV+3 with parity) after the start edge. An unacked byte is overwritten and flags overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ,
  parameter int BAUD       = UART_BAUD,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  uart_rx_state_t state, state_nxt;

  logic                      rx_m, rx_s;
  logic                      tick, mid, sample;
  logic                      restart, shift_en, load, fe_set;
  logic                      par_bad;
  logic [UART_DATA_BITS-1:0] shift_q, data_q;
  logic [BW-1:0]             bit_cnt;
  logic                      valid_q, overrun_q, frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                      par_cap, pe_set, par_err_q, parity_err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_baud_tick #(
    .DIV        (DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick),
    .mid     (mid)
  );

  // mid recurs every OVERSAMPLE ticks, so after the start-bit centre every later
  // mid tick lands on the centre of the next bit without another restart.
  assign sample = tick & mid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    fe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap   = 1'b0;
    pe_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          restart   = 1'b1;
        end
      end
      START: begin
        if (sample) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          load      = rx_s & ~par_bad;
          fe_set    = ~rx_s;
`ifdef UART_RX_PARITY_EN
          pe_set    = par_bad;
`endif
          state_nxt = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= fe_set;
      if (restart) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // A completing byte wins over an ack in the same cycle: the old byte is
      // consumed and the new one is presented without a gap.
      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (bus.rx_ack) begin
        valid_q <= 1'b0;
      end
      if (load && valid_q && !bus.rx_ack) overrun_q <= 1'b1;
      else if (valid_q && bus.rx_ack)     overrun_q <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= pe_set;
      if (restart)      par_err_q <= 1'b0;
      else if (par_cap) par_err_q <= rx_s ^ (^shift_q);
    end
  end

  assign par_bad        = par_err_q;
  assign bus.parity_err = parity_err_q;
`else
  assign par_bad        = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = (state != IDLE);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx at the default 50 MHz / 115200 baud: directed frames, with a scoreboard
// of expected byte and error events checked by a free-running monitor.
module tb_uart_rx;

  localparam int DIV = 27;          // 50e6 / (115200*16) = 27.1, truncated
  localparam int BIT = 16 * DIV;    // 432 clocks per bit
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;
  localparam int LAT = 4539;        // 168*27 + 3
`else
  localparam int NB  = 10;
  localparam int LAT = 4107;        // 152*27 + 3
`endif

  typedef enum int {EV_NONE, EV_DATA, EV_FE, EV_PE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         edge_n;
  } exp_t;

  exp_t       sb_q[$];
  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic       pv;
  logic [7:0] pd;
  int         g0;

  uart_rx_if bus();

  uart_rx dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) step(1);
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    step(1);
    bus.rx_ack = 1'b0;
  endtask

  // Sends one frame; ack_at >= 0 raises rx_ack for exactly edge e0+ack_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                            input ev_kind_t kind, input logic [7:0] exp_d,
                            input bit chk_lat, input int ack_at);
    logic [10:0] bits;
    exp_t        e;
    int          e0;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^b) ^ par_flip;
    bits[10]  = stop_b;
`else
    bits[9]   = stop_b;
    bits[10]  = par_flip;           // not transmitted in 8N1
`endif
    @(posedge clk);
    #1;
    e0 = cyc + 1;
    if (kind != EV_NONE) begin
      e.kind   = kind;
      e.data   = exp_d;
      e.edge_n = chk_lat ? e0 + LAT : -1;
      sb_q.push_back(e);
    end
    for (int i = 0; i < NB * BIT; i++) begin
      rx = bits[i / BIT];
      if (ack_at >= 0) bus.rx_ack = (i == ack_at);
      step(1);
    end
    if (ack_at >= 0) bus.rx_ack = 1'b0;
  endtask

  task automatic got(input ev_kind_t k, input logic [7:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h at edge %0d, required none",
               k, d, cyc);
    end else begin
      e = sb_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (k == EV_DATA && e.kind == EV_DATA) check("rx_data", 32'(d), 32'(e.data));
      if (e.edge_n >= 0) check("event_edge", cyc, e.edge_n);
    end
  endtask

  // A new byte shows as a valid rise, or as a data change while valid stays high.
  initial begin
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (bus.frame_err)  got(EV_FE, 8'h00);
        if (bus.parity_err) got(EV_PE, 8'h00);
        if (bus.rx_valid && (!pv || bus.rx_data != pd)) got(EV_DATA, bus.rx_data);
        pv = bus.rx_valid;
        pd = bus.rx_data;
      end
    end
  end

  initial begin
    reset      = 1'b1;
    rx         = 1'b1;
    bus.rx_ack = 1'b0;
    step(5);
    check("rst_data",    32'(bus.rx_data),    32'h00);
    check("rst_valid",   32'(bus.rx_valid),   0);
    check("rst_busy",    32'(bus.rx_busy),    0);
    check("rst_ferr",    32'(bus.frame_err),  0);
    check("rst_perr",    32'(bus.parity_err), 0);
    check("rst_overrun", 32'(bus.overrun),    0);
    reset = 1'b0;
    step(5);
    check("idle_busy", 32'(bus.rx_busy), 0);

    // Single byte with latency check, then consume it.
    send_frame(8'hA5, 1'b1, 1'b0, EV_DATA, 8'hA5, 1'b1, -1);
    check("a5_valid", 32'(bus.rx_valid), 1);
    check("a5_data",  32'(bus.rx_data),  32'hA5);
    step(10);
    ack_pulse();
    check("a5_ack_valid", 32'(bus.rx_valid), 0);

    // Glitch shorter than half a bit: rejected at the mid-start sample.
    step(BIT);
    rx = 1'b0;
    g0 = cyc + 1;
    step(4 * DIV);
    rx = 1'b1;
    wait_edge(g0 + 8 * DIV);
    check("glitch_busy_before_mid", 32'(bus.rx_busy), 1);
    wait_edge(g0 + 8 * DIV + 5);
    check("glitch_busy_after_mid", 32'(bus.rx_busy), 0);
    check("glitch_valid", 32'(bus.rx_valid), 0);

    // Stop bit low, line held low: one frame error, then BREAK until the line rises.
    step(BIT);
    send_frame(8'h3C, 1'b0, 1'b0, EV_FE, 8'h00, 1'b1, -1);
    step(20 * BIT);
    check("break_busy",  32'(bus.rx_busy),  1);
    check("break_valid", 32'(bus.rx_valid), 0);
    rx = 1'b1;
    step(5);
    check("break_exit_busy", 32'(bus.rx_busy), 0);

    // Back-to-back bytes without ack: overwrite and overrun.
    step(BIT);
    send_frame(8'h11, 1'b1, 1'b0, EV_DATA, 8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b0, EV_DATA, 8'h22, 1'b1, -1);
    step(5);
    check("ovr_flag",  32'(bus.overrun),  1);
    check("ovr_valid", 32'(bus.rx_valid), 1);
    check("ovr_data",  32'(bus.rx_data),  32'h22);
    ack_pulse();
    check("ovr_ack_valid", 32'(bus.rx_valid), 0);
    check("ovr_ack_flag",  32'(bus.overrun),  0);

    // Ack on the completion edge of the second byte: no overrun.
    send_frame(8'h33, 1'b1, 1'b0, EV_DATA, 8'h33, 1'b1, -1);
    send_frame(8'h44, 1'b1, 1'b0, EV_DATA, 8'h44, 1'b1, LAT);
    step(5);
    check("ackdone_overrun", 32'(bus.overrun),  0);
    check("ackdone_valid",   32'(bus.rx_valid), 1);
    check("ackdone_data",    32'(bus.rx_data),  32'h44);
    ack_pulse();
    check("ackdone_clear", 32'(bus.rx_valid), 0);

    // Reset during data bit 4 of 0xFF, then a clean 0x5A.
    step(BIT);
    rx = 1'b0;
    step(BIT);
    rx = 1'b1;
    step(4 * BIT + BIT / 2);
    check("midframe_busy", 32'(bus.rx_busy), 1);
    reset = 1'b1;
    step(2);
    check("midreset_busy", 32'(bus.rx_busy), 0);
    check("midreset_data", 32'(bus.rx_data), 32'h00);
    reset = 1'b0;
    step(BIT);
    send_frame(8'h5A, 1'b1, 1'b0, EV_DATA, 8'h5A, 1'b1, -1);
    step(5);
    check("after_reset_valid",   32'(bus.rx_valid), 1);
    check("after_reset_overrun", 32'(bus.overrun),  0);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even-parity bit is 1.
    send_frame(8'h07, 1'b1, 1'b0, EV_DATA, 8'h07, 1'b1, -1);
    send_frame(8'h07, 1'b1, 1'b1, EV_PE,   8'h00, 1'b1, -1);
    step(5);
    check("par_valid",   32'(bus.rx_valid), 1);
    check("par_data",    32'(bus.rx_data),  32'h07);
    check("par_overrun", 32'(bus.overrun),  0);
    ack_pulse();
`endif

    step(100);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
